mem_seq: RTL
============

Name: mem_seq

Overview:
Parametrised fetch/execute sequencer that drives a synchronous single-port RAM. It is the successor to the fixed 8-bit two-word store-only datapath. It fetches two-word instructions (word A = opcode + address, word B = data) and executes STORE, LOAD, JUMP and HALT. Run is edge-started and halt is sticky. An accumulator is added, and data and address widths are generalised.

Parameters:
DW, 8, data/instruction word width
AW, 6, address/PC width; must satisfy AW <= DW-2 (elaboration error otherwise)
PC_RESET, 0, PC value after reset

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
run  in  1  start request; rising edge starts execution from WAIT
waits  out  1  stage WAIT (one-hot with the four stage outputs)
fetcha  out  1  stage FA
fetchb  out  1  stage FB
execa  out  1  stage EA
execb  out  1  stage EB
pc_out  out  AW  program counter
ira  out  DW  instruction word A
irb  out  DW  instruction word B
acc  out  DW  accumulator
halted  out  1  sticky HALT flag
mem_addr  out  AW  RAM address
mem_wdata  out  DW  RAM write data
mem_rden  out  1  RAM read enable
mem_wren  out  1  RAM write enable
mem_rdata  in  DW  RAM q; valid the cycle after a read is issued

Behaviour:
- Reset (rst=0, async): state=WAIT, pc=PC_RESET, ira=irb=acc=0, halted=0, run_q=0.
  - Stage outputs: waits=1, others 0.
  - Memory outputs are decoded from state, so mem_rden=mem_wren=0 and mem_addr=0 immediately.
- run_q <= run every cycle. start = run & ~run_q.
- Opcode is ira[DW-1:DW-2]. Target address T = ira[AW-1:0].
  - 00 STORE, 01 LOAD, 10 JUMP, 11 HALT.
- States and transitions:
  - WAIT: if start, go to FA and clear halted. Otherwise stay. Start in any other state is ignored.
  - FA: mem_addr=pc, mem_rden=1, pc<=pc+1. Go to FB.
  - FB: mem_addr=pc, mem_rden=1, pc<=pc+1, ira<=mem_rdata. Go to EA.
  - EA: irb<=mem_rdata. Action depends on the opcode of ira (captured in FB):
    - STORE: mem_addr=T, mem_wdata=mem_rdata, mem_wren=1.
    - LOAD: mem_addr=T, mem_rden=1.
    - JUMP: pc<=T.
    - HALT: halted<=1, go to WAIT.
    - Non-HALT opcodes go to EB.
  - EB: LOAD does acc<=mem_rdata; other opcodes do nothing.
    - Then: if run=1, go to FA; else go to WAIT (paused; halted stays 0; pc retained).
- Idle outputs: mem_addr=0, mem_wdata=0 and enables 0 outside the cases above.
- Never rden and wren together.
- pc is modulo 2^AW: increment from 2^AW-1 wraps to 0, with no flag. A wrap between FA and FB is legal.
- Timing: each non-HALT instruction takes 4 cycles; HALT takes 3 then WAIT.
- Edge-start rule: run held high after HALT does not restart; run must go low then high.
- Reset mid-operation aborts at once; an EA write in progress is dropped (wren falls asynchronously).

Test Plan:
- DW=8,AW=6. RAM[0..5] = 05,A5,45,00,C0,00. Pulse run -> RAM[5]=A5; acc=A5; after the HALT instruction, waits=1, halted=1, pc=6. Total 11 cycles from FA to WAIT.
- RAM[0]=8A, RAM[10]=C0. Run -> JUMP in EA sets pc=0x0A; then HALT with pc=0x0C, ira=C0.
- PC_RESET=62. RAM[62]=45, RAM[63]=77, RAM[5]=3C. Run, holding run high -> fetches at 62 and 63, pc wraps to 0, acc=3C, next FA at addr 0.
- After a HALT, keep run=1 for 10 cycles -> stays WAIT. Drop run, then raise it -> FA next cycle, halted cleared.
- STORE in progress: assert rst=0 during EA -> mem_wren=0 the same cycle, RAM unchanged, all outputs at reset values.
- run dropped during FB of a LOAD -> LOAD completes (acc updated in EB), then WAIT with pc preserved. Next run edge resumes at that pc.

Source files
------------

// File: rtl/mem_seq_if.sv
// Memory-side bus of the mem_seq sequencer: one synchronous single-port RAM.
// The master owns address, write data and the enables; the RAM owns the read data.
interface mem_seq_if #(
  parameter int DW = 8,
  parameter int AW = 6
);
  // Protocol: no handshake. mem_rden and mem_wren are never high together.
  // When mem_rden is high in cycle N, the word at mem_addr appears on mem_rdata
  // in cycle N+1. When mem_wren is high, mem_wdata is written to mem_addr at the clock edge.
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_rden;
  logic          mem_wren;
  logic [DW-1:0] mem_rdata;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_rden,
    output mem_wren,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_rden,
    input  mem_wren,
    output mem_rdata
  );
endinterface

// File: rtl/mem_seq.sv
// Fetch/execute sequencer for two-word instructions (opcode+address, data) on a
// single-port RAM. It executes STORE, LOAD, JUMP and HALT, and keeps an accumulator.
module mem_seq #(
  parameter int          DW       = 8,
  parameter int          AW       = 6,
  parameter int unsigned PC_RESET = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          waits,
  output logic          fetcha,
  output logic          fetchb,
  output logic          execa,
  output logic          execb,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] ira,
  output logic [DW-1:0] irb,
  output logic [DW-1:0] acc,
  output logic          halted,
  mem_seq_if.master     mem
);

  // The 2-bit opcode sits above the target address in word A.
  if (AW > DW - 2) begin : g_bad_width
    $error("mem_seq: AW must be <= DW-2");
  end

  localparam logic [2:0] S_WAIT = 3'd0;
  localparam logic [2:0] S_FA   = 3'd1;
  localparam logic [2:0] S_FB   = 3'd2;
  localparam logic [2:0] S_EA   = 3'd3;
  localparam logic [2:0] S_EB   = 3'd4;

  localparam logic [1:0] OP_STORE = 2'b00;
  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_JUMP  = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  logic [2:0]    state;
  logic [AW-1:0] pc;
  logic          run_q;
  logic          start;
  logic [1:0]    opcode;
  logic [AW-1:0] target;

  assign start  = run & ~run_q;
  assign opcode = ira[DW-1:DW-2];
  assign target = ira[AW-1:0];
  assign pc_out = pc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_WAIT;
      pc     <= AW'(PC_RESET);
      ira    <= '0;
      irb    <= '0;
      acc    <= '0;
      halted <= 1'b0;
      run_q  <= 1'b0;
    end else begin
      run_q <= run;
      case (state)
        S_WAIT: begin
          if (start) begin
            state  <= S_FA;
            halted <= 1'b0;
          end
        end
        S_FA: begin
          pc    <= pc + AW'(1);
          state <= S_FB;
        end
        S_FB: begin
          pc    <= pc + AW'(1);
          ira   <= mem.mem_rdata;
          state <= S_EA;
        end
        S_EA: begin
          irb <= mem.mem_rdata;
          if (opcode == OP_JUMP) pc <= target;
          if (opcode == OP_HALT) begin
            halted <= 1'b1;
            state  <= S_WAIT;
          end else begin
            state <= S_EB;
          end
        end
        S_EB: begin
          if (opcode == OP_LOAD) acc <= mem.mem_rdata;
          // A paused program continues straight on while run is held high.
          state <= run ? S_FA : S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  always_comb begin
    waits  = (state == S_WAIT);
    fetcha = (state == S_FA);
    fetchb = (state == S_FB);
    execa  = (state == S_EA);
    execb  = (state == S_EB);
  end

  // The bus is decoded from state alone, so a reset drops any write at once.
  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_rden  = 1'b0;
    mem.mem_wren  = 1'b0;
    case (state)
      S_FA, S_FB: begin
        mem.mem_addr = pc;
        mem.mem_rden = 1'b1;
      end
      S_EA: begin
        if (opcode == OP_STORE) begin
          mem.mem_addr  = target;
          mem.mem_wdata = mem.mem_rdata;
          mem.mem_wren  = 1'b1;
        end else if (opcode == OP_LOAD) begin
          mem.mem_addr = target;
          mem.mem_rden = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
